hazard_stall_ctrl: RTL

Pipeline hazard/stall sequencer for the 5-stage MIPS core. It works alongside the operand-forwarding unit and covers the hazards forwarding cannot resolve:
- load-use: 1-cycle stall plus bubble;
- variable-latency data memory: whole-pipe freeze;
- taken branch resolved in EXE: IF/ID flush for FLUSH_SLOTS cycles.

It drives hold, bubble and flush strobes into the PC, IF/ID and ID/EXE registers.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/load_use_detect.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and widths for the pipeline hazard/stall sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hazard_state_e;

  localparam int unsigned REG_ZERO    = 0;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// Pure comparator: flags an ID source that depends on the load currently in EXE.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             exe_memread_i,
  input  logic [REG_W-1:0] exe_rd_i,
  output logic             load_use_o
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  // $zero is never a real dependency, so it cannot cause a stall
  assign rd_nonzero = (exe_rd_i != REG_W'(REG_ZERO));
  assign rs_match   = (exe_rd_i == id_rs_i);
  assign rt_match   = id_uses_rt_i && (exe_rd_i == id_rt_i);
  assign load_use_o = exe_memread_i && rd_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer: load-use stall, memory freeze with timeout, branch flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             exe_memread,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idexe_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [FLUSH_CNT_W-1:0] FlushReload = FLUSH_CNT_W'(FLUSH_SLOTS - 1);
  localparam logic [WAIT_CNT_W-1:0]  WaitLimit   = WAIT_CNT_W'(MEM_TIMEOUT);

  hazard_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;
  logic hold_c, bubble_c, flush_c, freeze_c, flush_evt;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .exe_memread_i (exe_memread),
    .exe_rd_i      (exe_rd),
    .load_use_o    (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    hold_c      = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    freeze_c    = 1'b0;
    flush_evt   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          freeze_c   = 1'b1;
          wait_cnt_d = WAIT_CNT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else if (branch_taken) begin
          // ID instruction is squashed, so any load-use on it is moot
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          flush_evt = 1'b1;
          if (FLUSH_SLOTS > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FlushReload;
          end
        end else if (load_use) begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WaitLimit) begin
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          freeze_c   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end

      ST_FLUSH: begin
        if (mem_stall) begin
          // Freeze pauses the flush sequence; no timeout in this state
          freeze_c = 1'b1;
        end else if (branch_taken) begin
          flush_c     = 1'b1;
          bubble_c    = 1'b1;
          flush_evt   = 1'b1;
          flush_cnt_d = FlushReload;
        end else begin
          flush_c = 1'b1;
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Strobes are forced low while reset is held, whatever the inputs do
  assign pc_hold      = RESET && hold_c;
  assign ifid_hold    = RESET && hold_c;
  assign idexe_bubble = RESET && bubble_c;
  assign ifid_flush   = RESET && flush_c;
  assign pipe_freeze  = RESET && freeze_c;
  assign mem_timeout  = timeout_q;
  assign state_o      = state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_ev_cnt_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q    <= '0;
      flush_ev_cnt_q <= '0;
    end else begin
      if ((hold_c || freeze_c) && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt && !(&flush_ev_cnt_q)) begin
        flush_ev_cnt_q <= flush_ev_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_ev_cnt_q;
`else
  logic unused_flush_evt;
  assign unused_flush_evt = flush_evt;
  assign stall_cycles     = '0;
  assign flush_count      = '0;
`endif

endmodule
